// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and a
// small helper for sizing the stage counter.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    XPORT,
    POR,
    SYS,
    RUN,
    SYSRST
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR,
    CAUSE_LOCK,
    CAUSE_DBG,
    CAUSE_SYSREQ
  } cause_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchroniser for an asynchronous level into hclk; clears to 0 on RESET.
module reset_seq_sync2 (
  input  logic hclk,
  input  logic RESET,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge hclk) begin
    if (RESET) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: qualifies both PLL locks, then releases transport,
// core POR and core system reset in turn; services debug POR / SYSRESETREQ.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int XPORT_LEAD_CYCLES  = 8,
  parameter int POR_CYCLES         = 255,
  parameter int SYS_CYCLES         = 16
) (
  input  logic       hclk,
  input  logic       RESET,
  input  logic       hpll_locked,
  input  logic       tpll_locked,
  input  logic       sysresetreq,
  input  logic       dbg_por_req,
  output logic       transport_rst_n,
  output logic       poreset_n,
  output logic       sysreset_n,
  output logic       ready,
  output logic [1:0] rst_cause
);

  localparam int MAXP = max_of4(LOCK_STABLE_CYCLES, XPORT_LEAD_CYCLES, POR_CYCLES, SYS_CYCLES);
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] XPORT_LAST = CW'(XPORT_LEAD_CYCLES - 1);
  localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LAST   = CW'(SYS_CYCLES - 1);

  logic          w_hpll_s;
  logic          w_tpll_s;
  logic          w_locked_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  cause_t        r_cause;
  cause_t        w_cause_nxt;

  reset_seq_sync2 u_sync_hpll (
    .hclk  (hclk),
    .RESET (RESET),
    .i_d   (hpll_locked),
    .o_q   (w_hpll_s)
  );

  reset_seq_sync2 u_sync_tpll (
    .hclk  (hclk),
    .RESET (RESET),
    .i_d   (tpll_locked),
    .o_q   (w_tpll_s)
  );

  assign w_locked_s = w_hpll_s & w_tpll_s;

  // Lock loss outranks every request; requests only matter in RUN/SYSRST.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_cnt_nxt   = r_cnt + 1'b1;

    if (r_state == WAIT_LOCK) begin
      if (!w_locked_s) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == LOCK_LAST) begin
        w_state_nxt = XPORT;
      end
    end else if (!w_locked_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cause_nxt = CAUSE_LOCK;
    end else begin
      case (r_state)
        XPORT:   if (r_cnt == XPORT_LAST) w_state_nxt = POR;
        POR:     if (r_cnt == POR_LAST)   w_state_nxt = SYS;
        SYS:     if (r_cnt == SYS_LAST)   w_state_nxt = RUN;
        RUN: begin
          if (dbg_por_req) begin
            w_state_nxt = POR;
            w_cause_nxt = CAUSE_DBG;
          end else if (sysresetreq) begin
            w_state_nxt = SYSRST;
            w_cause_nxt = CAUSE_SYSREQ;
          end
        end
        SYSRST: begin
          if (dbg_por_req) begin
            w_state_nxt = POR;
            w_cause_nxt = CAUSE_DBG;
          end else if (r_cnt == SYS_LAST) begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = WAIT_LOCK;
      endcase
    end

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they switch on the entry edge.
  always_ff @(posedge hclk) begin
    if (RESET) begin
      r_state         <= WAIT_LOCK;
      r_cnt           <= '0;
      r_cause         <= CAUSE_POR;
      transport_rst_n <= 1'b0;
      poreset_n       <= 1'b0;
      sysreset_n      <= 1'b0;
      ready           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_cause         <= w_cause_nxt;
      transport_rst_n <= (w_state_nxt != WAIT_LOCK);
      poreset_n       <= (w_state_nxt == SYS) || (w_state_nxt == RUN) || (w_state_nxt == SYSRST);
      sysreset_n      <= (w_state_nxt == RUN);
      ready           <= (w_state_nxt == RUN);
    end
  end

  assign rst_cause = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: milestone tables, hand-written request/lock/RESET
// sequences, and a random phase compared cycle-by-cycle against a timeline model.
module tb_reset_seq;

  localparam int L = 64;
  localparam int X = 8;
  localparam int P = 255;
  localparam int S = 16;

  logic       hclk = 1'b0;
  logic       RESET = 1'b1;
  logic       hpll = 1'b0;
  logic       tpll = 1'b0;
  logic       sysreq = 1'b0;
  logic       dbg = 1'b0;
  logic       trst, por, sys, rdy;
  logic [1:0] cause;
  logic [5:0] outs;

  assign outs = {trst, por, sys, rdy, cause};

  always #5 hclk = ~hclk;

  reset_seq #(
    .LOCK_STABLE_CYCLES (L),
    .XPORT_LEAD_CYCLES  (X),
    .POR_CYCLES         (P),
    .SYS_CYCLES         (S)
  ) dut (
    .hclk            (hclk),
    .RESET           (RESET),
    .hpll_locked     (hpll),
    .tpll_locked     (tpll),
    .sysresetreq     (sysreq),
    .dbg_por_req     (dbg),
    .transport_rst_n (trst),
    .poreset_n       (por),
    .sysreset_n      (sys),
    .ready           (rdy),
    .rst_cause       (cause)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (trst,por,sys,rdy,cause) at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Timeline model: phases with absolute end edges, lock seen two edges late.
  typedef enum {M_WAIT, M_XP, M_POR, M_SYS, M_RUN, M_SRST} mph_t;
  mph_t       m_ph = M_WAIT;
  logic [1:0] m_hist = 2'b00;
  logic [1:0] m_cause = 2'b00;
  int         m_run = 0;
  int         m_end = 0;
  int         m_k = 0;
  bit         chk_en = 1'b0;

  always @(posedge hclk) begin
    logic ls;
    m_k++;
    if (RESET) begin
      m_hist  = 2'b00;
      m_ph    = M_WAIT;
      m_run   = 0;
      m_cause = 2'd0;
    end else begin
      ls     = m_hist[1];
      m_hist = {m_hist[0], hpll & tpll};
      if (m_ph == M_WAIT) begin
        if (ls) begin
          m_run++;
          if (m_run == L) begin m_ph = M_XP; m_end = m_k + X; end
        end else m_run = 0;
      end else if (!ls) begin
        m_ph = M_WAIT; m_run = 0; m_cause = 2'd1;
      end else begin
        case (m_ph)
          M_XP:  if (m_k == m_end) begin m_ph = M_POR; m_end = m_k + P; end
          M_POR: if (m_k == m_end) begin m_ph = M_SYS; m_end = m_k + S; end
          M_SYS: if (m_k == m_end) m_ph = M_RUN;
          M_RUN: begin
            if (dbg) begin m_ph = M_POR; m_end = m_k + P; m_cause = 2'd2; end
            else if (sysreq) begin m_ph = M_SRST; m_end = m_k + S; m_cause = 2'd3; end
          end
          M_SRST: begin
            if (dbg) begin m_ph = M_POR; m_end = m_k + P; m_cause = 2'd2; end
            else if (m_k == m_end) m_ph = M_RUN;
          end
          default: m_ph = M_WAIT;
        endcase
      end
    end
  end

  always @(negedge hclk) begin
    if (chk_en)
      check("model", outs, {m_ph != M_WAIT,
                            m_ph == M_SYS || m_ph == M_RUN || m_ph == M_SRST,
                            m_ph == M_RUN, m_ph == M_RUN, m_cause});
  end

  typedef struct {
    int         sel;
    int         at;
    logic       hpll;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Edge 0 is the edge that still samples RESET high; release follows it.
  task automatic run_table(input int sel, input logic [1:0] c);
    int e;
    e = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel == sel) begin
        while (e < tbl[i].at) begin tick(); e++; end
        check($sformatf("tbl%0d_edge%0d", sel, e), outs, {tbl[i].exp, c});
        hpll = tbl[i].hpll;
      end
    end
  endtask

  initial begin
    int n;
    int down;

    // sel 0: clean power-up milestones
    tbl.push_back('{0,   2, 1'b1, 4'b0000});
    tbl.push_back('{0,  65, 1'b1, 4'b0000});
    tbl.push_back('{0,  66, 1'b1, 4'b1000});
    tbl.push_back('{0,  73, 1'b1, 4'b1000});
    tbl.push_back('{0,  74, 1'b1, 4'b1000});
    tbl.push_back('{0, 328, 1'b1, 4'b1000});
    tbl.push_back('{0, 329, 1'b1, 4'b1100});
    tbl.push_back('{0, 344, 1'b1, 4'b1100});
    tbl.push_back('{0, 345, 1'b1, 4'b1111});
    // sel 1: hpll glitch sampled at edge 40 restarts lock qualification
    tbl.push_back('{1,  39, 1'b0, 4'b0000});
    tbl.push_back('{1,  40, 1'b1, 4'b0000});
    tbl.push_back('{1,  66, 1'b1, 4'b0000});
    tbl.push_back('{1, 105, 1'b1, 4'b0000});
    tbl.push_back('{1, 106, 1'b1, 4'b1000});
    tbl.push_back('{1, 384, 1'b1, 4'b1100});
    tbl.push_back('{1, 385, 1'b1, 4'b1111});

    RESET = 1'b1; hpll = 1'b1; tpll = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    check("reset_state", outs, 6'b000000);
    RESET = 1'b0;
    run_table(0, 2'd0);

    // one-cycle SYSRESETREQ pulse
    tick();
    sysreq = 1'b1;
    tick();
    check("sysreq_enter", outs, 6'b110011);
    sysreq = 1'b0;
    n = 1;
    for (int i = 0; i < 40 && !sys; i++) begin tick(); if (!sys) n++; end
    check_int("sysreq_low_cycles", n, S);
    check("sysreq_done", outs, 6'b111111);

    // simultaneous requests: debug POR wins
    tick();
    sysreq = 1'b1; dbg = 1'b1;
    tick();
    check("both_enter", outs, 6'b100010);
    sysreq = 1'b0; dbg = 1'b0;
    n = 1;
    for (int i = 0; i < 400 && !por; i++) begin tick(); if (!por) n++; end
    check_int("dbg_por_low_cycles", n, P);
    check("dbg_sys_stage", outs, 6'b110010);
    n = 1;
    for (int i = 0; i < 40 && !sys; i++) begin tick(); if (!sys) n++; end
    check_int("dbg_sys_low_cycles", n, S);
    check("dbg_done", outs, 6'b111110);

    // transport PLL loss in RUN, then relock replays the sequence
    tick();
    tpll = 1'b0;
    tick(); tick();
    check("lockloss_edge2", outs, 6'b111110);
    tick();
    check("lockloss_edge3", outs, 6'b000001);
    repeat (5) tick();
    tpll = 1'b1;
    run_table(0, 2'd1);

    // RESET during the POR stage
    tick();
    dbg = 1'b1;
    tick();
    dbg = 1'b0;
    repeat (10) tick();
    RESET = 1'b1;
    tick();
    check("reset_mid_por", outs, 6'b000000);
    RESET = 1'b0;
    run_table(0, 2'd0);

    // lock glitch during qualification
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run_table(1, 2'd0);

    // random traffic against the model
    down = 0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if ($urandom_range(0, 99) < 3) sysreq = ~sysreq;
      if (!dbg && $urandom_range(0, 999) < 2) dbg = 1'b1;
      else if (dbg && $urandom_range(0, 9) < 3) dbg = 1'b0;
      if (down > 0) begin
        down--;
        if (down == 0) begin hpll = 1'b1; tpll = 1'b1; end
      end else if ($urandom_range(0, 1499) == 0) begin
        down = $urandom_range(1, 6);
        if ($urandom_range(0, 1) == 1) hpll = 1'b0; else tpll = 1'b0;
      end
      RESET = ($urandom_range(0, 3999) == 0);
    end
    RESET = 1'b0; sysreq = 1'b0; dbg = 1'b0; hpll = 1'b1; tpll = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
